apb2axi_rd_collector: RTL



---
 rtl/apb2axi_pkg.sv | 25 ++
 rtl/apb2axi_rd_beat_buf.sv | 23 ++
 rtl/apb2axi_rd_collector.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/apb2axi_pkg.sv
// Shared types for the APB-to-AXI bridge read return path: AXI response codes,
// the collector state encoding and the burst response merge rule.
package apb2axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axi_resp_e;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } rd_col_state_e;

  // Worst response wins; EXOKAY carries no meaning on the APB side, so it folds to OKAY.
  function automatic axi_resp_e resp_merge(input axi_resp_e a, input axi_resp_e b);
    if (a == DECERR || b == DECERR) return DECERR;
    if (a == SLVERR || b == SLVERR) return SLVERR;
    return OKAY;
  endfunction

endpackage

// File: rtl/apb2axi_rd_beat_buf.sv
// Beat storage for one AXI read burst: single write port, asynchronous read port.
module apb2axi_rd_beat_buf #(
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16,
  localparam int LEN_W    = $clog2(MAX_BEATS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LEN_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LEN_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [MAX_BEATS-1:0][DATA_W-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb2axi_rd_collector.sv
// Store-and-forward collector for one AXI read burst; beats drain with the merged response.
// Define APB2AXI_RD_TIMEOUT_EN to abort a stalled COLLECT after TIMEOUT_CYC idle cycles.
module apb2axi_rd_collector
  import apb2axi_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ID_W        = 4,
  parameter int MAX_BEATS   = 16,
  parameter int TIMEOUT_CYC = 1024,
  localparam int LEN_W      = $clog2(MAX_BEATS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic [ID_W-1:0]   rid,
  input  logic              rlast,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic [ID_W-1:0]   out_id,
  output logic [LEN_W-1:0]  out_beat,
  output logic              out_last,
  output logic [1:0]        out_resp,
  output logic              out_err
);

  if (MAX_BEATS < 2 || MAX_BEATS > 256 || (MAX_BEATS & (MAX_BEATS - 1)) != 0 || TIMEOUT_CYC < 1)
  begin : g_bad_param
    $error("apb2axi_rd_collector: illegal MAX_BEATS or TIMEOUT_CYC");
  end

  rd_col_state_e     state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  eff_len_q, eff_len_d;
  logic [LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [LEN_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic              err_q, err_d;
  axi_resp_e         resp_q, resp_d;
  logic              cmd_rdy_q, cmd_rdy_d;
  logic              rready_q, rready_d;
  logic              out_vld_q, out_vld_d;
  logic              beat;
  logic              empty;
  logic [DATA_W-1:0] buf_rdata;

`ifdef APB2AXI_RD_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            empty_q, empty_d;
  assign empty = empty_q;
`else
  assign empty = 1'b0;
`endif

  // rready_q is only ever set while in COLLECT, so it doubles as the state qualifier.
  assign beat = rvalid & rready_q;

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    len_d     = len_q;
    eff_len_d = eff_len_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    err_d     = err_q;
    resp_d    = resp_q;
`ifdef APB2AXI_RD_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    empty_d   = empty_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_vld && cmd_rdy_q) begin
          id_d     = cmd_id;
          len_d    = cmd_len;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
          err_d    = 1'b0;
          resp_d   = OKAY;
          state_d  = COLLECT;
`ifdef APB2AXI_RD_TIMEOUT_EN
          to_cnt_d = '0;
          empty_d  = 1'b0;
`endif
        end
      end
      COLLECT: begin
        if (beat) begin
          resp_d = resp_merge(resp_q, axi_resp_e'(rresp));
          if (rid != id_q) err_d = 1'b1;
          if (rlast && wr_cnt_q < len_q) begin
            err_d     = 1'b1;
            eff_len_d = wr_cnt_q;
            state_d   = DRAIN;
          end else if (wr_cnt_q == len_q) begin
            eff_len_d = len_q;
            if (!rlast) err_d = 1'b1;
            state_d   = DRAIN;
          end else begin
            wr_cnt_d = wr_cnt_q + LEN_W'(1);
          end
        end
`ifdef APB2AXI_RD_TIMEOUT_EN
        if (beat) begin
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          resp_d  = DECERR;
          state_d = DRAIN;
          // wr_cnt_q counts beats stored so far; zero means a single synthetic entry.
          if (wr_cnt_q == '0) begin
            eff_len_d = '0;
            empty_d   = 1'b1;
          end else begin
            eff_len_d = wr_cnt_q - LEN_W'(1);
          end
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      DRAIN: begin
        if (out_vld_q && out_rdy) begin
          if (rd_cnt_q == eff_len_q) state_d = IDLE;
          else                       rd_cnt_d = rd_cnt_q + LEN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    cmd_rdy_d = (state_d == IDLE);
    rready_d  = (state_d == COLLECT);
    out_vld_d = (state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      id_q      <= '0;
      len_q     <= '0;
      eff_len_q <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_q     <= 1'b0;
      resp_q    <= OKAY;
      cmd_rdy_q <= 1'b0;
      rready_q  <= 1'b0;
      out_vld_q <= 1'b0;
`ifdef APB2AXI_RD_TIMEOUT_EN
      to_cnt_q  <= '0;
      empty_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      len_q     <= len_d;
      eff_len_q <= eff_len_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      err_q     <= err_d;
      resp_q    <= resp_d;
      cmd_rdy_q <= cmd_rdy_d;
      rready_q  <= rready_d;
      out_vld_q <= out_vld_d;
`ifdef APB2AXI_RD_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
      empty_q   <= empty_d;
`endif
    end
  end

  apb2axi_rd_beat_buf #(
    .DATA_W    (DATA_W),
    .MAX_BEATS (MAX_BEATS)
  ) u_buf (
    .clk   (clk),
    .we    (beat),
    .waddr (wr_cnt_q),
    .wdata (rdata),
    .raddr (rd_cnt_q),
    .rdata (buf_rdata)
  );

  assign cmd_rdy  = cmd_rdy_q;
  assign rready   = rready_q;
  assign out_vld  = out_vld_q;
  assign out_data = (out_vld_q && !empty) ? buf_rdata : '0;
  assign out_id   = out_vld_q ? id_q : '0;
  assign out_beat = out_vld_q ? rd_cnt_q : '0;
  assign out_last = out_vld_q && (rd_cnt_q == eff_len_q);
  assign out_resp = out_vld_q ? resp_q : OKAY;
  assign out_err  = out_vld_q && err_q;

endmodule
